// File: rtl/red_iterativa_izq_der.sv
// Bit-serial MSB-first comparison network: one iterative cell per clock, from bit K-1 down to 0.
// Produces the prefix-equality vector N plus the final Z/gt/lt flags.
module red_iterativa_izq_der #(
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] N,
  output logic         Z,
  output logic         gt,
  output logic         lt
);

  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [K-1:0]    a_q, b_q, n_q;
  logic [IdxW-1:0] idx_q;
  logic            eq_q, gt_q, lt_q, z_q, busy_q, done_q;

  // Current cell: operand bits at idx and the equality carried into the next cell.
  logic a_bit, b_bit, eq_nxt;
  assign a_bit  = a_q[idx_q];
  assign b_bit  = b_q[idx_q];
  assign eq_nxt = eq_q & (a_bit == b_bit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            idx_q   <= IdxW'(K - 1);
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            n_q     <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Only the first differing cell may set a magnitude flag.
          if (eq_q && a_bit && !b_bit) gt_q <= 1'b1;
          if (eq_q && !a_bit && b_bit) lt_q <= 1'b1;
          eq_q       <= eq_nxt;
          n_q[idx_q] <= eq_nxt;
          if (idx_q == '0) begin
            z_q     <= eq_nxt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_red_iterativa_izq_der.sv
// Self-checking bench for red_iterativa_izq_der: directed cases plus random words,
// checked every cycle against a prefix-arithmetic reference model.
module tb_red_iterativa_izq_der;

  localparam int unsigned K = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [K-1:0] a_in = '0;
  logic [K-1:0] b_in = '0;
  logic         busy, done, z, gt, lt;
  logic [K-1:0] n_out;

  int vectors = 0;
  int miscompares = 0;

  red_iterativa_izq_der #(.K(K)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (a_in),
    .B    (b_in),
    .busy (busy),
    .done (done),
    .N    (n_out),
    .Z    (z),
    .gt   (gt),
    .lt   (lt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after j RUN edges (j=0 right after the start edge, j=K at done):
  // the top j cells are evaluated, so everything follows from the top j bits of A and B.
  task automatic check_cycle(input int j, input logic [K-1:0] a, input logic [K-1:0] b);
    logic [K-1:0] n_e;
    logic [K-1:0] ha, hb;
    n_e = '0;
    for (int i = 0; i < int'(K); i++)
      if (i >= int'(K) - j) n_e[i] = ((a >> i) == (b >> i));
    ha = a >> (int'(K) - j);
    hb = b >> (int'(K) - j);
    check($sformatf("busy[%0h/%0h j=%0d]", a, b, j), 32'(busy), 32'(j < int'(K)));
    check($sformatf("done[%0h/%0h j=%0d]", a, b, j), 32'(done), 32'(j == int'(K)));
    check($sformatf("N[%0h/%0h j=%0d]", a, b, j), 32'(n_out), 32'(n_e));
    check($sformatf("Z[%0h/%0h j=%0d]", a, b, j), 32'(z), 32'((j == int'(K)) && (a == b)));
    check($sformatf("gt[%0h/%0h j=%0d]", a, b, j), 32'(gt), 32'(ha > hb));
    check($sformatf("lt[%0h/%0h j=%0d]", a, b, j), 32'(lt), 32'(ha < hb));
  endtask

  // Drive start for one edge, then scramble A/B: they must not be sampled again.
  task automatic launch(input logic [K-1:0] a, input logic [K-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    a_in  = K'($urandom);
    b_in  = K'($urandom);
    check_cycle(0, a, b);
  endtask

  // Remaining K RUN edges; a spurious start with new words is injected before edge noise_at.
  task automatic run_rest(input logic [K-1:0] a, input logic [K-1:0] b, input int noise_at);
    for (int j = 1; j <= int'(K); j++) begin
      if (j == noise_at) begin
        start = 1'b1;
        a_in  = K'($urandom);
        b_in  = K'($urandom);
      end
      step();
      start = 1'b0;
      check_cycle(j, a, b);
    end
  endtask

  task automatic hold_check(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [K-1:0] n_e;
    for (int i = 0; i < int'(K); i++) n_e[i] = ((a >> i) == (b >> i));
    step();
    check("hold busy", 32'(busy), 32'(0));
    check("hold done", 32'(done), 32'(0));
    check("hold N", 32'(n_out), 32'(n_e));
    check("hold Z", 32'(z), 32'(a == b));
    check("hold gt", 32'(gt), 32'(a > b));
    check("hold lt", 32'(lt), 32'(a < b));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'(0));
    check({tag, " done"}, 32'(done), 32'(0));
    check({tag, " N"}, 32'(n_out), 32'(0));
    check({tag, " Z"}, 32'(z), 32'(0));
    check({tag, " gt"}, 32'(gt), 32'(0));
    check({tag, " lt"}, 32'(lt), 32'(0));
  endtask

  initial begin
    logic [K-1:0] ra, rb;

    // Reset state, with start asserted to show reset priority.
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("idle");

    // Equal words, then results held.
    launch(4'b1010, 4'b1010);
    run_rest(4'b1010, 4'b1010, 0);
    hold_check(4'b1010, 4'b1010);
    hold_check(4'b1010, 4'b1010);

    // Late difference: gt appears after the third RUN edge.
    launch(4'b1010, 4'b1000);
    run_rest(4'b1010, 4'b1000, 0);
    hold_check(4'b1010, 4'b1000);

    // MSB decides.
    launch(4'b0111, 4'b1000);
    run_rest(4'b0111, 4'b1000, 0);

    // start during RUN ignored; then back-to-back start in the done cycle.
    launch(4'b0001, 4'b0000);
    run_rest(4'b0001, 4'b0000, 2);
    launch(4'b0101, 4'b0110);
    run_rest(4'b0101, 4'b0110, 0);
    hold_check(4'b0101, 4'b0110);

    // Reset mid-run aborts without a done pulse.
    launch(4'b1100, 4'b0011);
    run_rest(4'b1100, 4'b0011, -1);
    launch(4'b1100, 4'b0011);
    step();
    check_cycle(1, 4'b1100, 4'b0011);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle("midreset");
    for (int c = 0; c < int'(K) + 2; c++) begin
      step();
      check_idle($sformatf("post-reset c=%0d", c));
    end
    launch(4'b0000, 4'b0000);
    run_rest(4'b0000, 4'b0000, 0);
    hold_check(4'b0000, 4'b0000);

    // Random words, random spurious starts, random back-to-back or held gaps.
    for (int t = 0; t < 40; t++) begin
      ra = K'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : K'($urandom);
      launch(ra, rb);
      run_rest(ra, rb, int'($urandom_range(0, K)));
      if ($urandom_range(0, 1) == 1) hold_check(ra, rb);
    end
    hold_check(ra, rb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/red_iterativa_izq_der.md
Name: red_iterativa_izq_der

Overview:
- Bit-serial, left-to-right (MSB-first) counterpart of the combinational right-to-left iterative comparison network.
- Latches two K-bit words and evaluates one cell per clock, from bit K-1 down to bit 0.
- Produces the per-cell prefix-equality vector N, the final equality flag Z, and the magnitude flags gt/lt.
- Shares A/B/N/Z naming and the K parameter with the combinational network, so the same tester stimulus can drive both and their results can be cross-checked.

Parameters:
K, 4, word width in bits and number of iterative cells (K >= 2)

Ports:
clk    input   1  rising-edge clock
rst_n  input   1  synchronous reset, active-low
start  input   1  request to latch A/B and begin a comparison
A      input   K  operand A, sampled only on an accepted start
B      input   K  operand B, sampled only on an accepted start
busy   output  1  high while cells are being evaluated (state RUN)
done   output  1  one-cycle pulse when bit 0 has been evaluated
N      output  K  N[i]=1 iff A[K-1:i]==B[K-1:i]; unevaluated cells read 0
Z      output  1  1 iff A==B; valid while in DONE
gt     output  1  1 iff A>B (unsigned); valid while in DONE
lt     output  1  1 iff A<B (unsigned); valid while in DONE

Behaviour:
- All state is updated only on the rising edge of clk.
- Reset: when rst_n=0 at an edge, the block enters IDLE and clears all outputs:
  - busy=0, done=0, N=0, Z=0, gt=0, lt=0.
  - Internal operand registers, bit index and running flags are also cleared.
  - Reset has priority over start and over any comparison in progress.
  - A reset mid-comparison aborts it; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch A and B into internal registers.
  - Set idx=K-1, running eq=1, gt=0, lt=0, N=0, Z=0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, one cell per edge, at index i=idx:
  - If eq=1 and Areg[i]>Breg[i]: eq←0, gt←1.
  - If eq=1 and Areg[i]<Breg[i]: eq←0, lt←1.
  - If eq=0, the flags are unchanged; the first difference decides.
  - N[i]←updated eq.
  - If i=0: Z←updated eq, busy←0, done←1, go to DONE. Otherwise idx←idx-1.
  - There is no early exit: every comparison takes exactly K RUN cycles.
- Latency:
  - Start accepted at edge e0; busy is high after e0.
  - done=1, with Z/gt/lt/N final, after edge eK, i.e. K cycles after e0.
- DONE:
  - done is high for exactly one cycle, then returns to 0.
  - N, Z, gt and lt hold until the next accepted start or reset.
  - start=1 in DONE, including the same cycle that done=1, is accepted exactly as in IDLE. Back-to-back comparisons therefore run with zero idle cycles.
  - If start=0 in DONE, the state stays DONE with results held.
- start while in RUN is ignored: no relatch and no restart.
- A and B changing while not being sampled have no effect.
- Invariants:
  - Exactly one of Z, gt, lt is 1 in DONE.
  - In IDLE/RUN, Z=0.
  - gt=lt=0 until the first differing cell is evaluated; after that the flag may appear during RUN.
  - Once N[i]=0, N[j]=0 for all j<i.
  - Z equals N[0] when done.
- Unsigned arithmetic only; no carries; idx width is clog2(K).

Test Plan:
- Equal words (K=4): A=1010, B=1010, pulse start → busy for 4 cycles; then done=1 for 1 cycle, N=1111, Z=1, gt=0, lt=0; results held afterwards.
- Late difference: A=1010, B=1000 → N=1100, Z=0, gt=1, lt=0. gt is already 1 after the third RUN edge, and done still arrives on the 4th.
- MSB decides: A=0111, B=1000 → N=0000, Z=0, lt=1, gt=0. After the 1st RUN edge, N[3]=0 and lt=1. done after 4 cycles.
- start during RUN:
  - Begin with A=0001, B=0000.
  - At RUN cycle 2, assert start with A=1111, B=0000.
  - Required: no restart, done after the original 4 cycles, N=1110, gt=1.
- Back-to-back:
  - Assert start in the done cycle with A=0101, B=0110.
  - Required: busy the next cycle; after 4 cycles N=1100, lt=1; prior results are overwritten only at the new start (N/Z cleared).
- Reset mid-run:
  - Drive rst_n=0 for 1 cycle at RUN cycle 2.
  - Required: busy=0, N=0, Z=gt=lt=0, no done pulse, state IDLE.
  - A subsequent start with A=B=0000 yields Z=1, N=1111 after 4 cycles.
